posit_result_buffer: RTL



---
 rtl/posit_result_buffer.sv | 114 +++++++++++
 1 files changed

// File: rtl/posit_result_buffer.sv
// Registered result FIFO between a posit opgroup and the writeback arbiter.
// It also keeps a sticky OR of the status flags of every retired entry.
package posit_pkg;
    typedef logic [4:0] status_t;  // {NV, DZ, OF, UF, NX}
endpackage

module posit_result_buffer #(
    parameter int  Width   = 32,
    parameter int  Depth   = 4,
    parameter type TagType = logic
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [Width-1:0]             result_i,
    input  posit_pkg::status_t           status_i,
    input  logic                         extension_bit_i,
    input  TagType                       tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [Width-1:0]             result_o,
    output posit_pkg::status_t           status_o,
    output logic                         extension_bit_o,
    output TagType                       tag_o,
    output posit_pkg::status_t           fflags_o,
    input  logic                         fflags_clr_i,
    output logic [$clog2(Depth+1)-1:0]   usage_o,
    output logic                         busy_o
);
    import posit_pkg::*;

    localparam int              PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int              CntW    = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0] r_result [Depth];
    status_t          r_status [Depth];
    logic             r_ext    [Depth];
    TagType           r_tag    [Depth];

    logic [PtrW-1:0]  r_wp;
    logic [PtrW-1:0]  r_rp;
    logic [CntW-1:0]  r_cnt;
    status_t          r_fflags;

    logic             w_full;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PtrW-1:0] ptr_incr(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    // Readiness deliberately ignores out_ready_i: a full buffer never takes a push.
    assign w_full      = (r_cnt == FullCnt);
    assign in_ready_o  = !w_full && !flush_i;
    assign out_valid_o = (r_cnt != '0);
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i && !flush_i;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (flush_i) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= ptr_incr(r_wp);
            if (w_pop)  r_rp <= ptr_incr(r_rp);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // NOTE: entry storage has no reset; the counter alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_result[r_wp] <= result_i;
            r_status[r_wp] <= status_i;
            r_ext[r_wp]    <= extension_bit_i;
            r_tag[r_wp]    <= tag_i;
        end
    end

    // A clear coinciding with a pop keeps only the popped status.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fflags <= '0;
        end else if (fflags_clr_i) begin
            r_fflags <= w_pop ? r_status[r_rp] : '0;
        end else if (w_pop) begin
            r_fflags <= r_fflags | r_status[r_rp];
        end
    end

    assign result_o        = r_result[r_rp];
    assign status_o        = r_status[r_rp];
    assign extension_bit_o = r_ext[r_rp];
    assign tag_o           = r_tag[r_rp];
    assign fflags_o        = r_fflags;
    assign usage_o         = r_cnt;
    assign busy_o          = out_valid_o;

endmodule
